// File: rtl/snake_body_ctrl.sv
// rtl/snake_body_ctrl.sv - sequencer for the free-running snake-body direction shift register
module snake_body_ctrl #(
  parameter int DEPTH    = 220,
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int LEN_INIT = 3,
  parameter int HEAD_X0  = 8,
  parameter int HEAD_Y0  = 8,
  parameter int LW       = $clog2(DEPTH + 1),
  localparam int XW      = $clog2(GRID_W),
  localparam int YW      = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    sr_out,
  output logic [1:0]    sr_in,
  input  logic          step_valid,
  input  logic [1:0]    step_dir,
  input  logic          step_grow,
  output logic          step_ready,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          seg_valid,
  output logic [XW-1:0] seg_x,
  output logic [YW-1:0] seg_y,
  output logic          seg_last,
  output logic          frame_done,
  output logic          hit
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LW > PW) ? LW : PW;
  localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  localparam logic [LW-1:0] LMAX = LW'(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_SCAN, S_GAP} state_t;

  // fwd=1 applies +dir (head advance), fwd=0 applies -dir (walk toward tail)
  function automatic logic [XW-1:0] move_x(input logic [XW-1:0] x, input logic [1:0] d, input logic fwd);
    logic inc, dec;
    inc = fwd ? (d == 2'd0) : (d == 2'd2);
    dec = fwd ? (d == 2'd2) : (d == 2'd0);
    if (inc)      move_x = (x == XMAX) ? '0 : x + XW'(1);
    else if (dec) move_x = (x == '0) ? XMAX : x - XW'(1);
    else          move_x = x;
  endfunction

  function automatic logic [YW-1:0] move_y(input logic [YW-1:0] y, input logic [1:0] d, input logic fwd);
    logic inc, dec;
    inc = fwd ? (d == 2'd1) : (d == 2'd3);
    dec = fwd ? (d == 2'd3) : (d == 2'd1);
    if (inc)      move_y = (y == YMAX) ? '0 : y + YW'(1);
    else if (dec) move_y = (y == '0) ? YMAX : y - YW'(1);
    else          move_y = y;
  endfunction

  state_t        state, state_nx;
  logic [PW-1:0] pos, pos_nx, head_slot, k;
  logic          pend, pend_nx, pend_grow;
  logic [1:0]    pend_dir;
  logic [XW-1:0] cur_x, base_x, nseg_x;
  logic [YW-1:0] cur_y, base_y, nseg_y;
  logic          flag;
  logic          k_last, commit, accept, in_body, is_last, hit_now, frame_hit;

  assign pos_nx    = (pos == PMAX) ? '0 : pos + PW'(1);
  assign k_last    = (state == S_SCAN) && (k == PMAX);
  assign commit    = k_last && pend;
  assign accept    = step_valid && step_ready;
  assign base_x    = (k == '0) ? head_x : cur_x;
  assign base_y    = (k == '0) ? head_y : cur_y;
  assign nseg_x    = move_x(base_x, sr_out, 1'b0);
  assign nseg_y    = move_y(base_y, sr_out, 1'b0);
  assign in_body   = CW'(k) < CW'(length);
  assign is_last   = (CW'(k) + CW'(1)) == CW'(length);
  assign hit_now   = in_body && (nseg_x == head_x) && (nseg_y == head_y);
  assign frame_hit = (k == '0) ? hit_now : (flag | hit_now);

  // Next state, pending-step bookkeeping and the register feed (recirculate by default)
  always_comb begin
    state_nx = state;
    sr_in    = sr_out;
    pend_nx  = pend;
    if (accept) pend_nx = 1'b1;
    case (state)
      S_INIT: begin
        sr_in = 2'd0;
        if (pos == PMAX) state_nx = S_SCAN;
      end
      S_SCAN: begin
        if (commit) begin
          sr_in    = pend_dir;
          pend_nx  = 1'b0;
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (pos_nx == head_slot) state_nx = S_SCAN;
      end
      default: state_nx = S_INIT;
    endcase
  end

  // State, rotating position, frame index and head slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      pos       <= '0;
      k         <= '0;
      head_slot <= '0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
      k     <= ((state == S_SCAN) && !k_last) ? k + PW'(1) : '0;
      if (commit) head_slot <= pos;
    end
  end

  // Step handshake: one pending move, accepted only outside INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_dir   <= 2'd0;
      pend_grow  <= 1'b0;
      step_ready <= 1'b0;
    end else begin
      pend <= pend_nx;
      if (accept) begin
        pend_dir  <= step_dir;
        pend_grow <= step_grow;
      end
      step_ready <= (state_nx != S_INIT) && !pend_nx;
    end
  end

  // Head position and body length move only on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_x <= XW'(HEAD_X0);
      head_y <= YW'(HEAD_Y0);
      length <= LW'(LEN_INIT);
    end else if (commit) begin
      head_x <= move_x(head_x, pend_dir, 1'b1);
      head_y <= move_y(head_y, pend_dir, 1'b1);
      if (pend_grow && (length != LMAX)) length <= length + LW'(1);
    end
  end

  // Body walk: stream segment coordinates and fold them into the frame collision flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x      <= '0;
      cur_y      <= '0;
      seg_x      <= '0;
      seg_y      <= '0;
      seg_valid  <= 1'b0;
      seg_last   <= 1'b0;
      flag       <= 1'b0;
      frame_done <= 1'b0;
      hit        <= 1'b0;
    end else if (state == S_SCAN) begin
      cur_x      <= nseg_x;
      cur_y      <= nseg_y;
      seg_x      <= nseg_x;
      seg_y      <= nseg_y;
      seg_valid  <= in_body;
      seg_last   <= is_last;
      flag       <= frame_hit;
      frame_done <= k_last;
      hit        <= k_last && frame_hit;
    end else begin
      seg_valid  <= 1'b0;
      seg_last   <= 1'b0;
      frame_done <= 1'b0;
      hit        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb/tb_snake_body_ctrl.sv - self-checking bench for snake_body_ctrl
module tb_snake_body_ctrl;

  localparam int DEPTH = 220;
  localparam int GW    = 16;
  localparam int GH    = 16;
  localparam int LEN0  = 3;
  localparam int HX0   = 8;
  localparam int HY0   = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    sr_out, sr_in;
  logic          step_valid = 1'b0;
  logic [1:0]    step_dir = 2'd0;
  logic          step_grow = 1'b0;
  logic          step_ready;
  logic [3:0]    head_x, head_y, seg_x, seg_y;
  logic [LW-1:0] length;
  logic          seg_valid, seg_last, frame_done, hit;

  snake_body_ctrl #(
    .DEPTH(DEPTH), .GRID_W(GW), .GRID_H(GH), .LEN_INIT(LEN0),
    .HEAD_X0(HX0), .HEAD_Y0(HY0), .LW(LW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sr_out(sr_out), .sr_in(sr_in),
    .step_valid(step_valid), .step_dir(step_dir), .step_grow(step_grow),
    .step_ready(step_ready), .head_x(head_x), .head_y(head_y), .length(length),
    .seg_valid(seg_valid), .seg_x(seg_x), .seg_y(seg_y), .seg_last(seg_last),
    .frame_done(frame_done), .hit(hit)
  );

  always #5 clk = ~clk;

  // external free-running shift register; filled with garbage while seeding
  logic [1:0] sr_mem [DEPTH];
  int sr_ptr = 0;
  bit seeding = 1'b1;
  assign sr_out = sr_mem[sr_ptr];
  always @(posedge clk) begin
    sr_mem[sr_ptr] <= seeding ? 2'($urandom) : sr_in;
    sr_ptr <= (sr_ptr == DEPTH - 1) ? 0 : sr_ptr + 1;
  end

  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wrapv(input int v, input int g);
    return ((v % g) + g) % g;
  endfunction

  function automatic int ddx(input int d);
    case (d)
      0:       return 1;
      2:       return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int ddy(input int d);
    case (d)
      1:       return 1;
      3:       return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int pack(input int x, input int y, input int l);
    return x * 256 + y * 2 + l;
  endfunction

  // reference model: list of cell coordinates, index 0 = head
  int mx[$], my[$];
  int m_len, m_pend, m_pdir, m_pgrow, m_acc;
  int exp_fd, exp_seg;
  bit seen_ready;
  int fv[$];
  int n_commit = 0, n_fd = 0;
  int mon_hit = 0, s1x = 0, s1y = 0;

  task automatic model_reset();
    mx.delete();
    my.delete();
    for (int i = 0; i <= LEN0; i++) begin
      mx.push_back(wrapv(HX0 - i, GW));
      my.push_back(HY0);
    end
    m_len = LEN0;
    m_pend = 0;
    exp_fd = 2 * DEPTH;
    exp_seg = DEPTH + 1;
    seen_ready = 1'b0;
    fv.delete();
  endtask

  task automatic frame_end();
    int h = 0;
    int nx, ny;
    chk("frame_done_cycle", cyc, exp_fd);
    chk("frame_seg_count", fv.size(), m_len);
    for (int i = 0; i < m_len && i < fv.size(); i++)
      chk("seg_xy_last", fv[i], pack(mx[i+1], my[i+1], (i == m_len - 1) ? 1 : 0));
    for (int i = 1; i <= m_len; i++)
      if (mx[i] == mx[0] && my[i] == my[0]) h = 1;
    chk("frame_hit", int'(hit), h);
    mon_hit = int'(hit);
    fv.delete();
    if (m_pend != 0 && m_acc < cyc) begin
      nx = wrapv(mx[0] + ddx(m_pdir), GW);
      ny = wrapv(my[0] + ddy(m_pdir), GH);
      mx.push_front(nx);
      my.push_front(ny);
      if (m_pgrow != 0 && m_len < DEPTH) m_len++;
      while (mx.size() > m_len + 1) begin
        void'(mx.pop_back());
        void'(my.pop_back());
      end
      m_pend = 0;
      n_commit++;
      chk("ready_after_commit", int'(step_ready), 1);
      exp_fd = cyc + 2 * DEPTH - 1;
      exp_seg = cyc + DEPTH;
    end else begin
      exp_fd = cyc + DEPTH;
      exp_seg = cyc + 1;
    end
    chk("head_x", int'(head_x), mx[0]);
    chk("head_y", int'(head_y), my[0]);
    chk("length", int'(length), m_len);
    n_fd++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!seen_ready && step_ready) begin
        chk("ready_rise_cycle", cyc, DEPTH);
        seen_ready = 1'b1;
      end
      if (m_pend != 0 && cyc == m_acc) chk("ready_drop_after_accept", int'(step_ready), 0);
      if (seg_valid) begin
        if (fv.size() == 0) begin
          chk("seg_start_cycle", cyc, exp_seg);
          s1x = int'(seg_x);
          s1y = int'(seg_y);
        end
        fv.push_back(pack(int'(seg_x), int'(seg_y), int'(seg_last)));
      end
      if (frame_done) frame_end();
      if (step_valid && step_ready) begin
        m_pend = 1;
        m_pdir = int'(step_dir);
        m_pgrow = int'(step_grow);
        m_acc = cyc + 1;
      end
    end
  end

  task automatic wait_fd(input string nm);
    int n0 = n_fd;
    int t = 0;
    while (n_fd == n0 && t < 3 * DEPTH) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk({"wait_frame_", nm}, n_fd - n0, 1);
  endtask

  task automatic wait_commit(input string nm);
    int n0 = n_commit;
    int t = 0;
    while (n_commit == n0 && t < 4 * DEPTH) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk({"wait_commit_", nm}, n_commit - n0, 1);
  endtask

  task automatic do_step(input int d, input int g);
    int t = 0;
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    step_valid = 1'b1;
    step_dir = 2'(d);
    step_grow = g[0];
    while (!ok && t < 4 * DEPTH) begin
      @(negedge clk);
      if (step_ready) ok = 1'b1;
      t++;
    end
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    chk("step_accepted", int'(ok), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_sr_in"}, int'(sr_in), 0);
    chk({nm, "_step_ready"}, int'(step_ready), 0);
    chk({nm, "_head_x"}, int'(head_x), HX0);
    chk({nm, "_head_y"}, int'(head_y), HY0);
    chk({nm, "_length"}, int'(length), LEN0);
    chk({nm, "_seg_valid"}, int'(seg_valid), 0);
    chk({nm, "_seg_x"}, int'(seg_x), 0);
    chk({nm, "_seg_y"}, int'(seg_y), 0);
    chk({nm, "_seg_last"}, int'(seg_last), 0);
    chk({nm, "_frame_done"}, int'(frame_done), 0);
    chk({nm, "_hit"}, int'(hit), 0);
  endtask

  typedef struct {
    int dir;
    int grow;
    int hx;
    int hy;
    int len;
    int s1x;
    int s1y;
    int exp_hit;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 0,  8,  9, 3,  8,  8, 0};
    tbl[1]  = '{0, 1,  9,  9, 4,  8,  9, 0};
    tbl[2]  = '{0, 0, 10,  9, 4,  9,  9, 0};
    tbl[3]  = '{0, 0, 11,  9, 4, 10,  9, 0};
    tbl[4]  = '{0, 0, 12,  9, 4, 11,  9, 0};
    tbl[5]  = '{0, 0, 13,  9, 4, 12,  9, 0};
    tbl[6]  = '{0, 0, 14,  9, 4, 13,  9, 0};
    tbl[7]  = '{0, 0, 15,  9, 4, 14,  9, 0};
    tbl[8]  = '{0, 0,  0,  9, 4, 15,  9, 0};
    tbl[9]  = '{1, 0,  0, 10, 4,  0,  9, 0};
    tbl[10] = '{2, 0, 15, 10, 4,  0, 10, 0};
    tbl[11] = '{3, 0, 15,  9, 4, 15, 10, 1};
    tbl[12] = '{3, 0, 15,  8, 4, 15,  9, 0};

    rst_n = 1'b0;
    seeding = 1'b1;
    repeat (DEPTH + 8) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    seeding = 1'b0;
    rst_n = 1'b1;

    wait_fd("first");
    chk("first_seg1_x", s1x, 7);
    chk("first_seg1_y", s1y, 8);
    chk("first_hit", mon_hit, 0);

    for (int i = 0; i < 13; i++) begin
      do_step(tbl[i].dir, tbl[i].grow);
      wait_commit("tbl");
      chk("tbl_head_x", int'(head_x), tbl[i].hx);
      chk("tbl_head_y", int'(head_y), tbl[i].hy);
      chk("tbl_length", int'(length), tbl[i].len);
      wait_fd("tbl");
      chk("tbl_seg1_x", s1x, tbl[i].s1x);
      chk("tbl_seg1_y", s1y, tbl[i].s1y);
      chk("tbl_hit", mon_hit, tbl[i].exp_hit);
    end

    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(0, 300)) @(posedge clk);
      do_step(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    wait_fd("settle_a");
    wait_fd("settle_b");
    wait_fd("settle_c");

    wait_fd("pre_reset");
    do_step(1, 1);
    repeat (60) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    wait_fd("post_reset");
    chk("post_reset_head_x", int'(head_x), HX0);
    chk("post_reset_head_y", int'(head_y), HY0);
    chk("post_reset_length", int'(length), LEN0);
    chk("post_reset_seg1_x", s1x, 7);
    chk("post_reset_seg1_y", s1y, 8);
    wait_fd("post_reset_b");
    wait_fd("post_reset_c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
